// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM command arbiter: pin-level command codes,
// refresh timing constants and the arbiter state encoding.
package sdram_arbiter_pkg;

    // Command encoding {CKE, CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [4:0] CMD_NOP  = 5'b10111;
    localparam logic [4:0] CMD_PREC = 5'b10010;
    localparam logic [4:0] CMD_AREF = 5'b10001;
    localparam logic [4:0] CMD_MRS  = 5'b10000;

    localparam int REF_PERIOD = 1500;
    localparam int AREF_STEPS = 10;

    // A10 high selects precharge-all during the refresh sequence
    localparam logic [11:0] ADDR_PALL = 12'h400;
    localparam logic [11:0] ADDR_ZERO = 12'h000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus between the init/write/read stages and the arbiter, plus the muxed
// SDRAM pin outputs.
interface sdram_arbiter_if;
    logic        flag_init;
    logic [4:0]  init_cmd;
    logic [11:0] init_addr;
    logic        wr_req;
    logic        rd_req;
    logic        wr_end;
    logic        rd_end;
    logic [4:0]  wr_cmd;
    logic [4:0]  rd_cmd;
    logic [11:0] wr_addr;
    logic [11:0] rd_addr;
    logic        wr_en;
    logic        rd_en;
    logic        aref_req;
    logic [4:0]  sdram_cmd;
    logic [11:0] sdram_addr;

    modport slave (
        input  flag_init, init_cmd, init_addr,
        input  wr_req, rd_req, wr_end, rd_end,
        input  wr_cmd, rd_cmd, wr_addr, rd_addr,
        output wr_en, rd_en, aref_req, sdram_cmd, sdram_addr
    );

    modport master (
        output flag_init, init_cmd, init_addr,
        output wr_req, rd_req, wr_end, rd_end,
        output wr_cmd, rd_cmd, wr_addr, rd_addr,
        input  wr_en, rd_en, aref_req, sdram_cmd, sdram_addr
    );
endinterface

// File: rtl/sdram_aref_timer.sv
// Auto-refresh period timer: raises ref_pend once per REF_PERIOD cycles after
// initialisation and holds it until the arbiter acknowledges it.
module sdram_aref_timer
    import sdram_arbiter_pkg::*;
(
    input  logic S_CLK,
    input  logic RST_N,
    input  logic flag_init,
    input  logic ref_ack,
    output logic ref_pend
);

    localparam logic [10:0] CNT_LAST = 11'(REF_PERIOD - 1);

    logic [10:0] cnt_q;
    logic [10:0] cnt_d;
    logic        ref_pend_q;
    logic        ref_pend_d;
    logic        wrap_s;

    // Next-state for the period counter and the pending flag; a wrap beats an ack
    always_comb begin
        wrap_s     = 1'b0;
        cnt_d      = cnt_q;
        ref_pend_d = ref_pend_q;
        if (flag_init) begin
            if (cnt_q == CNT_LAST) begin
                wrap_s = 1'b1;
                cnt_d  = 11'd0;
            end else begin
                cnt_d  = cnt_q + 11'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (wrap_s) begin
            ref_pend_d = 1'b1;
        end else if (ref_ack) begin
            ref_pend_d = 1'b0;
        end else begin
            ref_pend_d = ref_pend_q;
        end
    end

    // Timer state registers
    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q      <= 11'd0;
            ref_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ref_pend_q <= ref_pend_d;
        end
    end

    assign ref_pend = ref_pend_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: owns the pins after initialisation and hands them to
// refresh, write or read, with refresh taking priority over new traffic.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
(
    input  logic            S_CLK,
    input  logic            RST_N,
    sdram_arbiter_if.slave  bus
);

    localparam logic [3:0] STEP_LAST = 4'(AREF_STEPS - 1);

    state_e     state_q;
    state_e     state_d;
    logic [3:0] step_q;
    logic [3:0] step_d;
    logic       ref_pend_s;
    logic       ref_ack_s;

    sdram_aref_timer u_timer (
        .S_CLK     (S_CLK),
        .RST_N     (RST_N),
        .flag_init (bus.flag_init),
        .ref_ack   (ref_ack_s),
        .ref_pend  (ref_pend_s)
    );

    // Next-state and refresh-sequence step; requests are only looked at in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: begin
                if (bus.flag_init) state_d = ST_IDLE;
                else               state_d = ST_INIT;
            end
            ST_IDLE: begin
                if (ref_pend_s)       state_d = ST_AREF;
                else if (bus.wr_req)  state_d = ST_WRITE;
                else if (bus.rd_req)  state_d = ST_READ;
                else                  state_d = ST_IDLE;
            end
            ST_AREF: begin
                if (step_q == STEP_LAST) state_d = ST_IDLE;
                else                     state_d = ST_AREF;
            end
            ST_WRITE: begin
                if (bus.wr_end) state_d = ST_IDLE;
                else            state_d = ST_WRITE;
            end
            ST_READ: begin
                if (bus.rd_end) state_d = ST_IDLE;
                else            state_d = ST_READ;
            end
            default: state_d = ST_INIT;
        endcase
        if ((state_q == ST_AREF) && (state_d == ST_AREF)) begin
            step_d = step_q + 4'd1;
        end else begin
            step_d = 4'd0;
        end
    end

    assign ref_ack_s = (state_q == ST_IDLE) && ref_pend_s;

    // FSM registers
    always_ff @(posedge S_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_INIT;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Pin mux and grants, selected by the registered state only
    always_comb begin
        bus.sdram_cmd  = CMD_NOP;
        bus.sdram_addr = ADDR_ZERO;
        bus.wr_en      = 1'b0;
        bus.rd_en      = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.sdram_cmd  = bus.init_cmd;
                bus.sdram_addr = bus.init_addr;
            end
            ST_IDLE: begin
                bus.sdram_cmd  = CMD_NOP;
                bus.sdram_addr = ADDR_ZERO;
            end
            ST_AREF: begin
                bus.sdram_addr = ADDR_PALL;
                if (step_q == 4'd0)      bus.sdram_cmd = CMD_PREC;
                else if (step_q == 4'd2) bus.sdram_cmd = CMD_AREF;
                else                     bus.sdram_cmd = CMD_NOP;
            end
            ST_WRITE: begin
                bus.sdram_cmd  = bus.wr_cmd;
                bus.sdram_addr = bus.wr_addr;
                bus.wr_en      = 1'b1;
            end
            ST_READ: begin
                bus.sdram_cmd  = bus.rd_cmd;
                bus.sdram_addr = bus.rd_addr;
                bus.rd_en      = 1'b1;
            end
            default: begin
                bus.sdram_cmd  = CMD_NOP;
                bus.sdram_addr = ADDR_ZERO;
            end
        endcase
    end

    assign bus.aref_req = ref_pend_s && ((state_q == ST_WRITE) || (state_q == ST_READ));

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, init hand-off, refresh priority and
// timing, write/read arbitration and reset during a refresh sequence.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam logic [4:0]  WR_CMD  = 5'b10100;
    localparam logic [4:0]  RD_CMD  = 5'b10101;
    localparam logic [11:0] WR_ADDR = 12'h0A5;
    localparam logic [11:0] RD_ADDR = 12'h15A;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;
    int   cyc;

    sdram_arbiter_if bus ();

    sdram_arbiter dut (
        .S_CLK (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Continuous properties sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            vec_cnt++;
            if (bus.wr_en && bus.rd_en) begin
                err_cnt++;
                $display("FAIL mutex_en: wr_en=%b rd_en=%b at cyc %0d", bus.wr_en, bus.rd_en, cyc);
            end
            if (dut.state_q == ST_IDLE) begin
                vec_cnt++;
                if (bus.sdram_cmd !== CMD_NOP) begin
                    err_cnt++;
                    $display("FAIL idle_nop: got %b want %b at cyc %0d", bus.sdram_cmd, CMD_NOP, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flag_init = 1'b0; bus.init_cmd = CMD_MRS; bus.init_addr = 12'h123;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
        bus.wr_cmd = WR_CMD; bus.rd_cmd = RD_CMD; bus.wr_addr = WR_ADDR; bus.rd_addr = RD_ADDR;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_MRS || bus.sdram_addr !== 12'h123) begin
            err_cnt++;
            $display("FAIL rst_passthru: got %b/%h want %b/%h", bus.sdram_cmd, bus.sdram_addr, CMD_MRS, 12'h123);
        end
        vec_cnt++;
        if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.aref_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_outputs: wr_en=%b rd_en=%b aref_req=%b want 0/0/0", bus.wr_en, bus.rd_en, bus.aref_req);
        end
        bus.init_cmd = CMD_PREC;
        #1;
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_PREC) begin
            err_cnt++;
            $display("FAIL rst_follow: got %b want %b", bus.sdram_cmd, CMD_PREC);
        end
        bus.init_cmd = CMD_MRS;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // flag_init first sampled at edge t0; expects NOP until the first refresh at t0+1500
    task automatic wait_first_refresh(input int t0, input string tag);
        while (cyc < t0 - 1) begin
            tick();
            vec_cnt++;
            if (bus.sdram_cmd !== CMD_MRS) begin
                err_cnt++;
                $display("FAIL %s_init_cmd: got %b want %b at cyc %0d", tag, bus.sdram_cmd, CMD_MRS, cyc);
            end
        end
        bus.flag_init = 1'b1;
        tick();
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_NOP || bus.sdram_addr !== 12'h000) begin
            err_cnt++;
            $display("FAIL %s_enter_idle: got %b/%h want %b/000", tag, bus.sdram_cmd, bus.sdram_addr, CMD_NOP);
        end
        while (cyc < t0 + 1499) begin
            tick();
            vec_cnt++;
            if (bus.sdram_cmd !== CMD_NOP) begin
                err_cnt++;
                $display("FAIL %s_no_early_ref: got %b want %b at cyc %0d", tag, bus.sdram_cmd, CMD_NOP, cyc);
            end
        end
    endtask

    task automatic check_aref_seq(input string tag);
        logic [4:0] exp_cmd;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_cmd = (k == 0) ? CMD_PREC : ((k == 2) ? CMD_AREF : CMD_NOP);
            vec_cnt++;
            if (bus.sdram_cmd !== exp_cmd || bus.sdram_addr !== 12'h400 ||
                bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.aref_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL %s_step%0d: cmd=%b addr=%h wr_en=%b rd_en=%b aref_req=%b want %b/400/0/0/0",
                         tag, k, bus.sdram_cmd, bus.sdram_addr, bus.wr_en, bus.rd_en, bus.aref_req, exp_cmd);
            end
        end
    endtask

    task automatic test_init();
        wait_first_refresh(5, "init");
    endtask

    task automatic test_aref_priority();
        bus.wr_req = 1'b1;
        check_aref_seq("prio");
        tick();
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_NOP || bus.wr_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL prio_idle_after: cmd=%b wr_en=%b want %b/0", bus.sdram_cmd, bus.wr_en, CMD_NOP);
        end
        tick();
        vec_cnt++;
        if (bus.wr_en !== 1'b1 || bus.sdram_cmd !== WR_CMD || bus.sdram_addr !== WR_ADDR) begin
            err_cnt++;
            $display("FAIL prio_write: wr_en=%b cmd=%b addr=%h want 1/%b/%h", bus.wr_en, bus.sdram_cmd, bus.sdram_addr, WR_CMD, WR_ADDR);
        end
    endtask

    task automatic test_write_refresh();
        while (cyc < 3003) begin
            tick();
            vec_cnt++;
            if (bus.wr_en !== 1'b1 || bus.aref_req !== 1'b0) begin
                err_cnt++;
                $display("FAIL wref_hold: wr_en=%b aref_req=%b want 1/0 at cyc %0d", bus.wr_en, bus.aref_req, cyc);
            end
        end
        tick();
        vec_cnt++;
        if (bus.aref_req !== 1'b1 || bus.wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL wref_aref_req: aref_req=%b wr_en=%b want 1/1", bus.aref_req, bus.wr_en);
        end
        bus.wr_req = 1'b0;
        tick();
        vec_cnt++;
        if (bus.aref_req !== 1'b1 || bus.wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL wref_owner_keeps: aref_req=%b wr_en=%b want 1/1", bus.aref_req, bus.wr_en);
        end
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        vec_cnt++;
        if (bus.wr_en !== 1'b0 || bus.aref_req !== 1'b0 || bus.sdram_cmd !== CMD_NOP) begin
            err_cnt++;
            $display("FAIL wref_idle: wr_en=%b aref_req=%b cmd=%b want 0/0/%b", bus.wr_en, bus.aref_req, bus.sdram_cmd, CMD_NOP);
        end
        check_aref_seq("wref");
        tick();
    endtask

    task automatic test_back_to_back();
        bus.wr_end = 1'b1; bus.rd_end = 1'b1;
        tick();
        bus.wr_end = 1'b0; bus.rd_end = 1'b0;
        vec_cnt++;
        if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.sdram_cmd !== CMD_NOP) begin
            err_cnt++;
            $display("FAIL stray_end_idle: wr_en=%b rd_en=%b cmd=%b want 0/0/%b", bus.wr_en, bus.rd_en, bus.sdram_cmd, CMD_NOP);
        end
        bus.wr_req = 1'b1; bus.rd_req = 1'b1;
        tick();
        vec_cnt++;
        if (bus.wr_en !== 1'b1 || bus.rd_en !== 1'b0 || bus.sdram_cmd !== WR_CMD) begin
            err_cnt++;
            $display("FAIL both_req_write: wr_en=%b rd_en=%b cmd=%b want 1/0/%b", bus.wr_en, bus.rd_en, bus.sdram_cmd, WR_CMD);
        end
        bus.wr_req = 1'b0; bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        vec_cnt++;
        if (bus.wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL rd_end_in_write: wr_en=%b want 1", bus.wr_en);
        end
        bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
        vec_cnt++;
        if (bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.sdram_cmd !== CMD_NOP) begin
            err_cnt++;
            $display("FAIL b2b_gap: wr_en=%b rd_en=%b cmd=%b want 0/0/%b", bus.wr_en, bus.rd_en, bus.sdram_cmd, CMD_NOP);
        end
        tick();
        vec_cnt++;
        if (bus.rd_en !== 1'b1 || bus.wr_en !== 1'b0 || bus.sdram_cmd !== RD_CMD || bus.sdram_addr !== RD_ADDR) begin
            err_cnt++;
            $display("FAIL b2b_read: rd_en=%b wr_en=%b cmd=%b addr=%h want 1/0/%b/%h",
                     bus.rd_en, bus.wr_en, bus.sdram_cmd, bus.sdram_addr, RD_CMD, RD_ADDR);
        end
        bus.rd_req = 1'b0; bus.wr_req = 1'b1;
        tick();
        vec_cnt++;
        if (bus.rd_en !== 1'b1 || bus.wr_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL wr_req_in_read: rd_en=%b wr_en=%b want 1/0", bus.rd_en, bus.wr_en);
        end
        bus.rd_end = 1'b1;
        tick();
        bus.rd_end = 1'b0;
        vec_cnt++;
        if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
            err_cnt++;
            $display("FAIL read_end_idle: rd_en=%b wr_en=%b want 0/0", bus.rd_en, bus.wr_en);
        end
        tick();
        vec_cnt++;
        if (bus.wr_en !== 1'b1) begin
            err_cnt++;
            $display("FAIL req_resampled: wr_en=%b want 1", bus.wr_en);
        end
        bus.wr_req = 1'b0; bus.wr_end = 1'b1;
        tick();
        bus.wr_end = 1'b0;
    endtask

    task automatic test_reset_mid_aref();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            tick();
            if (bus.sdram_cmd === CMD_PREC) found = 1'b1;
        end
        vec_cnt++;
        if (!found || cyc != 4505) begin
            err_cnt++;
            $display("FAIL third_refresh: found=%b at cyc %0d want 1 at 4505", found, cyc);
        end
        repeat (3) tick();
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_NOP || bus.sdram_addr !== 12'h400) begin
            err_cnt++;
            $display("FAIL aref_step3: cmd=%b addr=%h want %b/400", bus.sdram_cmd, bus.sdram_addr, CMD_NOP);
        end
        #2;
        rst_n = 1'b0;
        bus.flag_init = 1'b0;
        #1;
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_MRS || bus.wr_en !== 1'b0 || bus.rd_en !== 1'b0 || bus.aref_req !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_rst: cmd=%b wr_en=%b rd_en=%b aref_req=%b want %b/0/0/0",
                     bus.sdram_cmd, bus.wr_en, bus.rd_en, bus.aref_req, CMD_MRS);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        wait_first_refresh(3, "rerun");
        tick();
        vec_cnt++;
        if (bus.sdram_cmd !== CMD_PREC) begin
            err_cnt++;
            $display("FAIL rerun_refresh: cmd=%b want %b at cyc %0d", bus.sdram_cmd, CMD_PREC, cyc);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        cyc     = 0;
        test_reset();
        test_init();
        test_aref_priority();
        test_write_refresh();
        test_back_to_back();
        test_reset_mid_aref();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 S_CLK  in  1  system clock, 100 MHz; all state is updated on its rising edge.
REQ-002 RST_N  in  1  reset, asynchronous, active-low.
REQ-003 flag_init  in  1  init-sequence-complete level from the init stage; stays high once set.
REQ-004 init_cmd  in  5  init-stage command {CKE,CS_N,RAS_N,CAS_N,WE_N}.
REQ-005 init_addr  in  12  init-stage address.
REQ-006 wr_req / rd_req  in  1 each  write / read request level from the write and read stages.
REQ-007 wr_end / rd_end  in  1 each  one-cycle pulse: the write / read stage has finished its burst.
REQ-008 wr_cmd, rd_cmd  in  5 each; wr_addr, rd_addr  in  12 each  command/address from the write and read stages.
REQ-009 wr_en / rd_en  out  1 each  grant level; high for the whole WRITE / READ state.
REQ-010 aref_req  out  1  refresh pending while a write or read is granted; the owner must finish its current burst.
REQ-011 sdram_cmd  out  5  muxed command to the SDRAM pins.
REQ-012 sdram_addr  out  12  muxed address to the SDRAM pins.

Function
REQ-013 Command codes: NOP=5'b10111, PREC=5'b10010, AREF=5'b10001.
REQ-014 FSM states: INIT, IDLE, AREF, WRITE, READ; the state register is the only register driving the output mux select.
REQ-015 INIT: sdram_cmd=init_cmd and sdram_addr=init_addr (combinational pass-through); go to IDLE on the first cycle flag_init=1.
REQ-016 IDLE priority: refresh pending > wr_req > rd_req; the decision is taken in one cycle, and the next state is entered on the following edge.
REQ-017 IDLE outputs: sdram_cmd=NOP, sdram_addr=12'h000.
REQ-018 Refresh timer: 11-bit counter that runs only while flag_init=1.
  - Counts 0..1499, then wraps to 0.
  - The wrap cycle sets ref_pend.
REQ-019 ref_pend clears on the edge that enters AREF; if a timer wrap occurs on the same edge, set wins and ref_pend stays 1.
REQ-020 AREF sequence, driven by a 4-bit step counter starting at 0 on entry:
  - step 0: PREC, addr 12'h400 (A10=1, precharge all).
  - step 2: AREF, addr 12'h400.
  - other steps: NOP, addr 12'h400.
  - Return to IDLE on the edge after step 9 (AREF state lasts 10 cycles).
REQ-021 WRITE: sdram_cmd=wr_cmd, sdram_addr=wr_addr, wr_en=1; return to IDLE on the edge where wr_end=1.
REQ-022 READ: sdram_cmd=rd_cmd, sdram_addr=rd_addr, rd_en=1; return to IDLE on the edge where rd_end=1.
REQ-023 aref_req = ref_pend AND (state is WRITE or READ); it is combinational.
REQ-024 A wr_req or rd_req in any state other than IDLE is ignored (not latched); requests are levels and are re-sampled in IDLE.
REQ-025 wr_end or rd_end outside its matching state has no effect.
REQ-026 Back-to-back traffic: after an end pulse, at least one IDLE cycle (NOP) separates two grants.
REQ-027 wr_en and rd_en are never high together, and neither is high in INIT or AREF.

Reset
REQ-028 On RST_N low, the block resets immediately:
  - state=INIT;
  - refresh counter=0, ref_pend=0, step counter=0;
  - wr_en=0, rd_en=0, aref_req=0;
  - sdram_cmd follows init_cmd.
REQ-029 Reset asserted mid-WRITE, READ or AREF aborts the operation with no completion handshake; after release, operation restarts from INIT.

Structure
REQ-030 The shared package holds:
  - command codes NOP, PREC, AREF, MRS;
  - REF_PERIOD=1500, AREF_STEPS=10;
  - the FSM state encoding.
REQ-031 The refresh timer and ref_pend logic go in one sub-module, sdram_aref_timer (ports: S_CLK, RST_N, flag_init, ref_ack, ref_pend).

Verification
REQ-032 Reset, then raise flag_init at cycle 5 -> INIT->IDLE at cycle 6; sdram_cmd=NOP thereafter; first ref_pend 1500 cycles after flag_init.
REQ-033 In IDLE, ref_pend=1 with wr_req=1 in the same cycle -> AREF wins; sequence PREC at step 0 and AREF at step 2 with addr 12'h400; 10 cycles later IDLE, then WRITE with wr_en=1.
REQ-034 Timer wraps during WRITE -> aref_req=1 the same cycle; wr_end pulse -> IDLE, then AREF; wr_en=0 throughout AREF.
REQ-035 wr_req=1 and rd_req=1 simultaneously in IDLE, no refresh -> WRITE; after wr_end, IDLE for 1 cycle, then READ with rd_en=1 and sdram_cmd=rd_cmd.
REQ-036 RST_N low at AREF step 3 -> state=INIT and wr_en=rd_en=0 immediately; after release, no AREF is issued until flag_init and a new 1500-cycle period elapse.
REQ-037 Throughout all tests, assertion checks: wr_en and rd_en never both high; sdram_cmd equals NOP in IDLE.
